// File: rtl/sumador8b.sv
// 8-bit registered adder/accumulator behind the standard
// 8-in / 8-out / 8-bidir tile pad interface.
module sumador8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [7:0]       ui_in,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    logic             en;
    logic             op;
    logic             cin;
    logic             out_sel;

    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             ovf;

    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic             zero;
    logic             neg;
    logic [7:0]       status;

    // Upper control bits are reserved; tie them off so they reach nothing.
    logic             unused_ctrl;

    assign en      = ui_in[0];
    assign op      = ui_in[1];
    assign cin     = ui_in[2];
    assign out_sel = ui_in[3];

    assign unused_ctrl = &{1'b0, ui_in[7:4]};

    // Full 9-bit sum including carry-in, plus signed overflow of that sum.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, uio_in} + {{WIDTH{1'b0}}, cin};
        sum_ovf = (acc[WIDTH-1] == uio_in[WIDTH-1]) &&
                  (sum[WIDTH-1] != acc[WIDTH-1]);
    end

    // Accumulator and flags: reset wins, then load/add when selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (ena && en) begin
            if (op) begin
                acc   <= uio_in;
                carry <= 1'b0;
                ovf   <= 1'b0;
            end else begin
                acc   <= sum[WIDTH-1:0];
                carry <= sum[WIDTH];
                ovf   <= sum_ovf;
            end
        end
    end

    assign zero   = (acc == '0);
    assign neg    = acc[WIDTH-1];
    assign status = {4'b0000, neg, zero, ovf, carry};

    // Output selection is purely combinational on out_sel.
    always_comb begin
        uo_out = out_sel ? status : acc;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_sumador8b.sv
// Self-checking bench for sumador8b: queue scoreboard fed by
// a reference model, plus fixed expectations for key cases.
module tb_sumador8b;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] st;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] m_acc;
    logic       m_c;
    logic       m_v;

    logic [7:0] obs_acc;
    logic [7:0] obs_st;

    sumador8b #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%02h want=%02h", tag, got, want);
        end
    endtask

    // One clock: drive inputs, push model result, compare after the edge.
    task automatic step(input logic r, input logic e, input logic en,
                        input logic op, input logic cin,
                        input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] nacc;
        exp_t       x;
        exp_t       got;
        rst    = r;
        ena    = e;
        uio_in = b;
        ui_in  = {4'($urandom_range(0, 15)), 1'b0, cin, op, en};
        if (r) begin
            m_acc = 8'h00;
            m_c   = 1'b0;
            m_v   = 1'b0;
        end else if (e && en) begin
            if (op) begin
                m_acc = b;
                m_c   = 1'b0;
                m_v   = 1'b0;
            end else begin
                s     = m_acc + b + cin;
                nacc  = s[7:0];
                m_v   = (m_acc[7] == b[7]) && (nacc[7] != m_acc[7]);
                m_c   = s[8];
                m_acc = nacc;
            end
        end
        x.acc = m_acc;
        x.st  = {4'b0000, m_acc[7], (m_acc == 8'h00), m_v, m_c};
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        ui_in[3] = 1'b0;
        #1;
        obs_acc = uo_out;
        ui_in[3] = 1'b1;
        #1;
        obs_st = uo_out;
        ui_in[3] = 1'b0;
        chk("uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got=0 want=1");
        end else begin
            got = exp_q.pop_front();
            chk("sb_acc", obs_acc, got.acc);
            chk("sb_st", obs_st, got.st);
        end
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_acc  = 8'h00;
        m_c    = 1'b0;
        m_v    = 1'b0;
        @(negedge clk);

        step(1, 1, 1, 0, 0, 8'h55);
        step(1, 1, 1, 0, 0, 8'h55);
        chk("rst_acc", obs_acc, 8'h00);
        chk("rst_st", obs_st, 8'h04);

        step(0, 1, 1, 1, 0, 8'h10);
        chk("load10", obs_acc, 8'h10);
        step(0, 1, 1, 0, 0, 8'h20);
        chk("add20", obs_acc, 8'h30);
        chk("add20_st", obs_st, 8'h00);

        step(0, 1, 1, 1, 0, 8'hFF);
        step(0, 1, 1, 0, 0, 8'h01);
        chk("wrap_acc", obs_acc, 8'h00);
        chk("wrap_st", obs_st, 8'h05);

        step(0, 1, 1, 1, 0, 8'h7F);
        step(0, 1, 1, 0, 0, 8'h01);
        chk("ovf_acc", obs_acc, 8'h80);
        chk("ovf_st", obs_st, 8'h0A);

        step(0, 1, 1, 1, 0, 8'h80);
        step(0, 1, 1, 0, 0, 8'h80);
        chk("negovf_acc", obs_acc, 8'h00);
        chk("negovf_st", obs_st, 8'h07);

        step(0, 1, 1, 1, 0, 8'h05);
        step(0, 1, 1, 0, 1, 8'h03);
        chk("cin_acc", obs_acc, 8'h09);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, i[0], i[1], 8'($urandom));
            chk("hold_en", obs_acc, 8'h09);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, i[0], i[1], 8'($urandom));
            chk("hold_ena", obs_acc, 8'h09);
        end

        step(1, 1, 1, 0, 0, 8'h01);
        chk("midrst_acc", obs_acc, 8'h00);
        chk("midrst_st", obs_st, 8'h04);

        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom),
                 8'($urandom));
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_left got=%0d want=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sumador8b.md
Name: sumador8b

Overview:
8-bit registered adder/accumulator for a Tiny Tapeout user slot. On each enabled clock it either loads an operand or adds an operand (plus carry-in) into an 8-bit accumulator, and keeps carry and signed-overflow flags. The accumulator or a status byte is presented on the dedicated outputs. It sits directly behind the tile's standard 8-in / 8-out / 8-bidir pad interface.

Parameters:
WIDTH, 8, accumulator/operand width. The pad mapping below is fixed for 8.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  tile select; when low, all state holds
ui_in  input  8  control: [0] en, [1] op (0 = add, 1 = load), [2] cin, [3] out_sel, [7:4] unused/ignored
uio_in  input  8  operand B
uo_out  output  8  accumulator or status byte, selected by out_sel
uio_out  output  8  tied to 0x00
uio_oe  output  8  tied to 0x00; all bidirectional pins are inputs

Behaviour:
- One clock domain. There is no asynchronous path into state.
- State:
  - acc[7:0]
  - carry (1 bit)
  - ovf (1 bit)
- Reset: while rst=1 at a rising edge, acc<=0x00, carry<=0, ovf<=0. Reset has priority over en, ena and op, and is honoured mid-operation.
- Update at a rising edge when rst=0, ena=1 and ui_in[0]=1:
  - op=1 (load): acc<=uio_in; carry<=0; ovf<=0.
  - op=0 (add): 9-bit result R = acc + uio_in + cin, unsigned. acc<=R[7:0] (wraps mod 256); carry<=R[8].
  - op=0 (add), overflow: ovf<=1 iff acc[7]==uio_in[7] and R[7]!=acc[7] (two's-complement overflow; cin is included in R).
- Hold: if ena=0 or ui_in[0]=0 (and rst=0), acc, carry and ovf keep their values regardless of uio_in, op or cin.
- Derived flags (combinational from registers):
  - zero = (acc==0x00)
  - neg = acc[7]
- Output mux (combinational from registers and ui_in[3]):
  - out_sel=0: uo_out = acc.
  - out_sel=1: uo_out = {4'b0000, neg, zero, ovf, carry}, i.e. bit0 carry, bit1 ovf, bit2 zero, bit3 neg.
- Latency: a load/add result appears on uo_out one edge after the enabled edge. Toggling out_sel changes uo_out immediately, with no clock needed.
- After reset: uo_out=0x00 when out_sel=0, and 0x04 when out_sel=1 (zero flag set).
- uio_out and uio_oe are constant 0x00 at all times, including during reset.
- ui_in[7:4] has no effect on any output or state.
- Back-to-back enabled cycles each perform one operation; there is no pipeline hazard because acc feeds back directly.

Test Plan:
- Reset: hold rst=1 for 2 edges with en=1, op=0, uio_in=0x55 -> uo_out=0x00; set out_sel=1 -> uo_out=0x04; uio_oe=0x00 and uio_out=0x00.
- Load then add: en=1, op=1, uio_in=0x10 (1 edge) -> 0x10. Then op=0, uio_in=0x20, cin=0 -> 0x30; status=0x00.
- Unsigned wrap: load 0xFF, add 0x01 -> acc=0x00; status=0x05 (carry, zero).
- Signed overflow: load 0x7F, add 0x01 -> acc=0x80; status=0x0A (ovf, neg). Load 0x80, add 0x80 -> acc=0x00; status=0x07.
- Carry-in and hold:
  - load 0x05, add 0x03 with cin=1 -> 0x09.
  - Then en=0 with uio_in toggling for 5 edges -> stays 0x09.
  - Then en=1, ena=0 -> stays 0x09.
- Reset mid-operation: acc=0x09, en=1, op=0, uio_in=0x01, rst=1 for 1 edge -> acc=0x00 (not 0x0A), carry=0, ovf=0.
